// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer.
// Holds the FSM state encoding and the default word width.
package piso_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with a valid/ready load port and a
// bit-rate strobe (shift_en). The first bit appears one cycle after the word
// is accepted. A new word may be accepted in the final-bit cycle, so
// consecutive words stream out with no gap.
// Optional feature: define PISO_PARITY_EN to append one even-parity bit
// (XOR of the data bits) after every word.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             data_out,
  output logic             data_out_valid,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  assign last_bit  = (state == SHIFT) && (cnt == LAST);
  assign accept    = load_valid && load_ready;
  assign first_bit = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  // sreg still holds the bit currently on data_out at its head, so the
  // upcoming bit is the neighbour of the head.
  assign next_bit  = MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
  assign busy      = (state != IDLE);

  // Ready in IDLE, or in the final-bit cycle when that bit retires this edge.
`ifdef PISO_PARITY_EN
  assign load_ready = (state == IDLE) || ((state == PARITY) && shift_en);
`else
  assign load_ready = (state == IDLE) || (last_bit && shift_en);
`endif

  // FSM, bit counter, shift register and registered serial outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      sreg           <= '0;
      data_out       <= 1'b0;
      data_out_valid <= 1'b0;
`ifdef PISO_PARITY_EN
      par            <= 1'b0;
`endif
    end else if (accept) begin
      // Accept wins in every state where it can happen (IDLE or final bit).
      state          <= SHIFT;
      cnt            <= '0;
      sreg           <= load_data;
      data_out       <= first_bit;
      data_out_valid <= 1'b1;
`ifdef PISO_PARITY_EN
      par            <= ^load_data;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (shift_en) begin
            if (cnt == LAST) begin
              cnt <= '0;
`ifdef PISO_PARITY_EN
              state    <= PARITY;
              data_out <= par;
`else
              state          <= IDLE;
              data_out       <= 1'b0;
              data_out_valid <= 1'b0;
`endif
            end else begin
              cnt      <= cnt + 1'b1;
              sreg     <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
              data_out <= next_bit;
            end
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          if (shift_en) begin
            state          <= IDLE;
            data_out       <= 1'b0;
            data_out_valid <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (WIDTH=8).
// Two instances share stimulus: one MSB-first, one LSB-first.
// Builds with or without PISO_PARITY_EN; expectations follow the macro.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int PL = 1;
`else
  localparam int PL = 0;
`endif
  localparam int WL = 8 + PL;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       shift_en = 1'b0;

  logic lr_m, do_m, dv_m, busy_m;
  logic lr_l, do_l, dv_l, busy_l;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(lr_m), .shift_en(shift_en), .data_out(do_m),
    .data_out_valid(dv_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(lr_l), .shift_en(shift_en), .data_out(do_l),
    .data_out_valid(dv_l), .busy(busy_l)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // exp holds the expected stream, first bit at exp[8]; exp[0] is parity.
  task automatic run_word(input string name, input logic [7:0] d,
                          input bit lsb, input logic [8:0] exp);
    logic o_do, o_dv, o_lr, o_busy;
    shift_en = 1'b1; load_valid = 1'b1; load_data = d;
    #1;
    o_lr = lsb ? lr_l : lr_m;
    total++;
    if (o_lr !== 1'b1) $display("FAIL %s ready: got %b want 1", name, o_lr);
    else pass_cnt++;
    step();
    load_valid = 1'b0; load_data = 8'h00;
    for (int i = 0; i < WL; i++) begin
      o_do = lsb ? do_l : do_m;
      o_dv = lsb ? dv_l : dv_m;
      total++;
      if (o_dv !== 1'b1 || o_do !== exp[8-i])
        $display("FAIL %s bit%0d: got do=%b v=%b want do=%b v=1", name, i, o_do, o_dv, exp[8-i]);
      else pass_cnt++;
      step();
    end
    o_do = lsb ? do_l : do_m;
    o_dv = lsb ? dv_l : dv_m;
    o_busy = lsb ? busy_l : busy_m;
    total++;
    if (o_dv !== 1'b0 || o_do !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL %s idle: got do=%b v=%b busy=%b want 0/0/0", name, o_do, o_dv, o_busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_valid = 1'b0; shift_en = 1'b0;
    step(); step();
    total++;
    if (do_m !== 1'b0 || dv_m !== 1'b0 || busy_m !== 1'b0)
      $display("FAIL reset_outs: got do=%b v=%b busy=%b want 0/0/0", do_m, dv_m, busy_m);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total++;
    if (lr_m !== 1'b1 || lr_l !== 1'b1)
      $display("FAIL reset_ready: got %b/%b want 1/1", lr_m, lr_l);
    else pass_cnt++;
    step();
  endtask

  task automatic test_msb_first();
    run_word("msb_B0", 8'hB0, 1'b0, {8'b1011_0000, 1'b1});
    run_word("msb_B5", 8'hB5, 1'b0, {8'b1011_0101, 1'b1});
  endtask

  task automatic test_lsb_first();
    run_word("lsb_0D", 8'h0D, 1'b1, {8'b1011_0000, 1'b1});
  endtask

  task automatic test_parity_zero();
    run_word("msb_0F", 8'h0F, 1'b0, {8'b0000_1111, 1'b0});
  endtask

  task automatic test_back_to_back();
    logic [7:0] wd [2];
    logic       wp [2];
    logic       e;
    int         w, k;
    wd[0] = 8'hB5; wd[1] = 8'h0D;
    wp[0] = 1'b1;  wp[1] = 1'b1;
    shift_en = 1'b1; load_valid = 1'b1; load_data = 8'hB5;
    step();
    load_valid = 1'b0; load_data = 8'h00;
    for (int i = 0; i < 2*WL; i++) begin
      w = i / WL;
      k = i % WL;
      e = (k < 8) ? wd[w][7-k] : wp[w];
      total++;
      if (dv_m !== 1'b1 || do_m !== e)
        $display("FAIL b2b bit%0d: got do=%b v=%b want do=%b v=1", i, do_m, dv_m, e);
      else pass_cnt++;
      if (w == 0 && k == WL-1) begin
        load_valid = 1'b1; load_data = 8'h0D;
        #1;
        total++;
        if (lr_m !== 1'b1) $display("FAIL b2b ready_final: got %b want 1", lr_m);
        else pass_cnt++;
      end
      step();
      load_valid = 1'b0; load_data = 8'h00;
    end
    total++;
    if (dv_m !== 1'b0) $display("FAIL b2b end_valid: got %b want 0", dv_m);
    else pass_cnt++;
  endtask

  // shift_en pattern 1,0,0,1 repeating: odd bits are held 3 cycles, even 1.
  task automatic test_stall();
    logic [8:0] exp;
    logic [3:0] pat;
    int idx, c;
    exp = {8'b1010_0110, 1'b0};
    pat = 4'b1001;
    idx = 0; c = 0;
    shift_en = 1'b1; load_valid = 1'b1; load_data = 8'hA6;
    step();
    load_valid = 1'b0;
    while (idx < WL && c < 64) begin
      total++;
      if (dv_m !== 1'b1 || do_m !== exp[8-idx])
        $display("FAIL stall c%0d bit%0d: got do=%b v=%b want do=%b v=1", c, idx, do_m, dv_m, exp[8-idx]);
      else pass_cnt++;
      shift_en = pat[3 - (c % 4)];
      // junk offers mid-word must be ignored
      load_valid = (idx < WL-1) && c[0];
      load_data = 8'h5A ^ 8'(c);
      if (idx == WL-1) begin
        #1;
        total++;
        if (lr_m !== shift_en)
          $display("FAIL stall ready_final c%0d: got %b want %b", c, lr_m, shift_en);
        else pass_cnt++;
      end
      step();
      if (shift_en) idx++;
      c++;
    end
    load_valid = 1'b0; shift_en = 1'b1;
    total++;
    if (dv_m !== 1'b0 || c !== 16 + PL)
      $display("FAIL stall end: got v=%b cycles=%0d want v=0 cycles=%0d", dv_m, c, 16 + PL);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    shift_en = 1'b1; load_valid = 1'b1; load_data = 8'hFF;
    step();
    load_valid = 1'b0;
    step(); step();
    #2 reset = 1'b1;
    #1;
    total++;
    if (do_m !== 1'b0 || dv_m !== 1'b0 || busy_m !== 1'b0)
      $display("FAIL reset_mid outs: got do=%b v=%b busy=%b want 0/0/0", do_m, dv_m, busy_m);
    else pass_cnt++;
    #2 reset = 1'b0;
    step();
    run_word("post_reset_01", 8'h01, 1'b0, {8'b0000_0001, 1'b1});
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_parity_zero();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
